cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Responder side of the functional-unit → common-data-bus result handshake. Functional units (alu, mul, div, mem) raise a require line with a result and its reservation-station label. This block grants exactly one requester per cycle with round-robin fairness and returns a one-cycle accept. It registers the winner onto the broadcast bus (BCEN/BClabel/BCdata), which feeds the register file, reservation stations and operand queues.

Parameters:
N_SRC, 4, number of requesting units; index 0 alu, 1 mul, 2 div, 3 mem
DATA_W, 32, result data width
LABEL_W, 4, reservation-station label width; label 0 = "no producer"

Ports:
clk  input  1  clock; all state updates on rising edge
nRST  input  1  asynchronous active-low reset
require  input  N_SRC  per-unit request; held high with stable data/label until accepted
src_data  input  N_SRC*DATA_W  packed result data; slice i belongs to unit i
src_label  input  N_SRC*LABEL_W  packed result labels; slice i belongs to unit i
requireAC  output  N_SRC  one-hot accept, combinational from require and RR pointer
BCEN  output  1  broadcast valid, registered
BClabel  output  LABEL_W  broadcast label, registered
BCdata  output  DATA_W  broadcast data, registered
proto_err  output  1  sticky: a request was accepted with label 0

Behaviour:
- Reset (nRST=0, async): rr_ptr=0, BCEN=0, BClabel=0, BCdata=0, proto_err=0.
- requireAC is combinational.
  - Search starts at index rr_ptr and proceeds upward modulo N_SRC.
  - The first i with require[i]=1 gets requireAC[i]=1; all other bits are 0.
  - If no require bit is set, requireAC=0.
  - requireAC is 0 while nRST=0.
- The grant does not depend on any downstream ready. The bus accepts one result every cycle.
- Clock edge with a grant to unit g:
  - If src_label slice g != 0: BCEN<=1, BClabel<=src_label[g], BCdata<=src_data[g].
  - If src_label slice g == 0: BCEN<=0, BClabel<=0, BCdata<=0, proto_err<=1. The result is dropped but still accepted.
  - rr_ptr <= (g+1) mod N_SRC.
- Clock edge with no grant: BCEN<=0, BClabel<=0, BCdata<=0, rr_ptr unchanged.
- Latency: a result accepted in cycle t is on the bus in cycle t+1 for exactly one cycle.
  - Back-to-back grants give continuous BCEN=1 with a new label each cycle.
- Requester rule: a unit seeing requireAC[i]=1 at an edge has been consumed.
  - If require[i] is still high in the next cycle, that is treated as a new result.
  - A unit never waits for BCEN.
- Starvation bound: a continuously asserted request is accepted within N_SRC cycles.
- Simultaneous events:
  - All four requesting with rr_ptr=2: grant order is 2, 3, 0, 1.
  - A request arriving in the same cycle another unit is accepted competes normally next cycle.
- A request whose require drops before accept is silently withdrawn. Nothing is broadcast.
- Reset mid-operation:
  - A broadcast pending in BC registers is lost.
  - Units are reset by the same nRST and re-issue nothing.
  - After release, arbitration restarts at index 0.
- proto_err clears only on reset.
- No arithmetic except the pointer increment, which wraps at N_SRC (not a power-of-2 assumption; use an explicit compare).

Decomposition:
- Shared package:
  - SRC_ALU=0, SRC_MUL=1, SRC_DIV=2, SRC_MEM=3
  - LABEL_NONE=0
  - DATA_W and LABEL_W defaults, also used by the reservation stations and the register file
- One sub-module: rr_grant, holding the rotating-priority one-hot grant logic plus the rr_ptr register with async reset.
- Top level: operand slicing and the broadcast register stage.

Test Plan:
1. Reset: hold nRST=0 with require=4'b1111 → requireAC=0, BCEN=0, BClabel=0, BCdata=0. After release, first grant is requireAC=4'b0001.
2. Single request: require[1]=1, label 4'h5, data 32'h0000_0064 for one cycle → requireAC=4'b0010 that cycle. Next cycle BCEN=1, BClabel=5, BCdata=100. Following cycle BCEN=0.
3. Round-robin: all four hold require with labels 1, 2, 3, 4 → accept order 0, 1, 2, 3, 0 on consecutive cycles. BClabel sequence is 1, 2, 3, 4, 1 one cycle later, with BCEN continuously 1.
4. Fairness mid-rotation: rr_ptr=2 (after a grant to unit 1), require=4'b1011 → order 3, 0, 1. Unit 2 is never granted.
5. Label-0 error: require[3]=1 with label 0 → requireAC[3]=1, BCEN stays 0 next cycle, proto_err=1 and remains 1 until nRST pulse.
6. Reset during broadcast: grant unit 0 (label 7), assert nRST=0 asynchronously before the next edge → BCEN drops to 0 immediately. No label-7 broadcast occurs after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source indices and helpers for the common-data-bus arbiter.
package cdb_arbiter_pkg;

    localparam int unsigned N_SRC   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LABEL_W = 4;
    localparam int unsigned PTR_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_MUL = 1;
    localparam int unsigned SRC_DIV = 2;
    localparam int unsigned SRC_MEM = 3;

    // Label 0 means "no producer"; it must never appear on the bus.
    localparam logic [LABEL_W-1:0] LABEL_NONE = '0;

    // Index base+off modulo N_SRC; off is always < N_SRC so one subtract suffices.
    function automatic logic [PTR_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= N_SRC) s = s - N_SRC;
        return PTR_W'(s);
    endfunction

    // Pointer increment with an explicit wrap so N_SRC need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_SRC - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_grant.sv
// Rotating-priority one-hot grant with its round-robin pointer.
module cdb_arbiter_rr_grant
    import cdb_arbiter_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_SRC-1:0] req_i,
    output logic [N_SRC-1:0] gnt_c_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Search upward from ptr_q for the first requester; no grant during reset.
    always_comb begin
        gnt_c_o = '0;
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            cand = wrap_idx(32'(ptr_q), k);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                win_idx        = cand;
                gnt_c_o[cand]  = 1'b1;
            end
        end
        if (!rst_n_i) begin
            gnt_c_o = '0;
            found   = 1'b0;
        end
        ptr_d = found ? ptr_inc(win_idx) : ptr_q;
    end

    // Pointer register: moves to just past the winner, holds when idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Functional-unit result arbiter driving the registered common data bus.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       nRST,
    input  logic [N_SRC-1:0]           require,
    input  logic [N_SRC*DATA_W-1:0]    src_data,
    input  logic [N_SRC*LABEL_W-1:0]   src_label,
    output logic [N_SRC-1:0]           requireAC,
    output logic                       BCEN,
    output logic [LABEL_W-1:0]         BClabel,
    output logic [DATA_W-1:0]          BCdata,
    output logic                       proto_err
);

    logic [N_SRC-1:0]   gnt;
    logic [LABEL_W-1:0] sel_label;
    logic [DATA_W-1:0]  sel_data;

    logic               bc_en_q,    bc_en_d;
    logic [LABEL_W-1:0] bc_label_q, bc_label_d;
    logic [DATA_W-1:0]  bc_data_q,  bc_data_d;
    logic               err_q,      err_d;

    cdb_arbiter_rr_grant u_rr_grant (
        .clk_i   (clk),
        .rst_n_i (nRST),
        .req_i   (require),
        .gnt_c_o (gnt)
    );

    assign requireAC = gnt;

    // One-hot mux of the winner's label and data.
    always_comb begin
        sel_label = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                sel_label = sel_label | src_label[i*LABEL_W +: LABEL_W];
                sel_data  = sel_data  | src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next bus state: broadcast a valid winner, drop (and flag) a label-0 winner.
    always_comb begin
        bc_en_d    = 1'b0;
        bc_label_d = LABEL_NONE;
        bc_data_d  = '0;
        err_d      = err_q;
        if (|gnt) begin
            if (sel_label != LABEL_NONE) begin
                bc_en_d    = 1'b1;
                bc_label_d = sel_label;
                bc_data_d  = sel_data;
            end else begin
                err_d      = 1'b1;
            end
        end
    end

    // Broadcast stage and sticky protocol error; a pending broadcast is lost on reset.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            bc_en_q    <= 1'b0;
            bc_label_q <= LABEL_NONE;
            bc_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            bc_en_q    <= bc_en_d;
            bc_label_q <= bc_label_d;
            bc_data_q  <= bc_data_d;
            err_q      <= err_d;
        end
    end

    assign BCEN      = bc_en_q;
    assign BClabel   = bc_label_q;
    assign BCdata    = bc_data_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic                     clk;
    logic                     nRST;
    logic [N_SRC-1:0]         require;
    logic [N_SRC*DATA_W-1:0]  src_data;
    logic [N_SRC*LABEL_W-1:0] src_label;
    logic [N_SRC-1:0]         requireAC;
    logic                     BCEN;
    logic [LABEL_W-1:0]       BClabel;
    logic [DATA_W-1:0]        BCdata;
    logic                     proto_err;

    int n_checks;
    int n_pass;

    cdb_arbiter dut (
        .clk       (clk),
        .nRST      (nRST),
        .require   (require),
        .src_data  (src_data),
        .src_label (src_label),
        .requireAC (requireAC),
        .BCEN      (BCEN),
        .BClabel   (BClabel),
        .BCdata    (BCdata),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_src(input int i, input logic [LABEL_W-1:0] lbl, input logic [DATA_W-1:0] dat);
        src_label[i*LABEL_W +: LABEL_W] = lbl;
        src_data[i*DATA_W +: DATA_W]    = dat;
    endtask

    // Advance past the next rising edge to a stable sampling point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic en, input logic [LABEL_W-1:0] lbl,
                             input logic [DATA_W-1:0] dat);
        check({tag, ".en"},    32'(BCEN),    32'(en));
        check({tag, ".label"}, 32'(BClabel), 32'(lbl));
        check({tag, ".data"},  32'(BCdata),  32'(dat));
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        nRST      = 1'b0;
        require   = '0;
        src_data  = '0;
        src_label = '0;
        set_src(0, 4'h1, 32'h10);
        set_src(1, 4'h2, 32'h20);
        set_src(2, 4'h3, 32'h30);
        set_src(3, 4'h4, 32'h40);

        // Reset with all units requesting: no accept, idle bus.
        require = 4'b1111;
        #2;
        check("rst.ac", 32'(requireAC), 32'h0);
        check_bus("rst.bus", 1'b0, 4'h0, 32'h0);
        check("rst.err", 32'(proto_err), 32'h0);
        tick();
        check("rst.ac_held", 32'(requireAC), 32'h0);
        nRST = 1'b1;
        #1;
        check("rel.ac", 32'(requireAC), 32'b0001);
        tick();
        check_bus("rel.bus", 1'b1, 4'h1, 32'h10);
        require = '0;
        #1;
        check("idle.ac", 32'(requireAC), 32'h0);
        tick();
        check("idle.en", 32'(BCEN), 32'h0);

        // Single request from mul, pointer at 1.
        set_src(1, 4'h5, 32'h64);
        require = 4'b0010;
        #1;
        check("single.ac", 32'(requireAC), 32'b0010);
        tick();
        require = '0;
        check_bus("single.bus", 1'b1, 4'h5, 32'd100);
        tick();
        check("single.after", 32'(BCEN), 32'h0);

        // Async reset pulse mid-cycle restarts arbitration at 0.
        set_src(1, 4'h2, 32'h20);
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        #1;

        // Round-robin with all four requesting: 0,1,2,3,0 and continuous BCEN.
        require = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr.ac%0d", k), 32'(requireAC), 32'(1 << (k % 4)));
            tick();
            check($sformatf("rr.en%0d", k), 32'(BCEN), 32'h1);
            check($sformatf("rr.label%0d", k), 32'(BClabel), 32'((k % 4) + 1));
            check($sformatf("rr.data%0d", k), 32'(BCdata), 32'(((k % 4) + 1) * 16));
        end
        require = '0;
        tick();
        check("rr.idle", 32'(BCEN), 32'h0);

        // Pointer at 1: grant unit 1 to move it to 2, then 1011 gives 3,0,1.
        require = 4'b0010;
        #1;
        check("fair.pre", 32'(requireAC), 32'b0010);
        tick();
        require = 4'b1011;
        #1;
        check("fair.ac3", 32'(requireAC), 32'b1000);
        tick();
        check("fair.lbl3", 32'(BClabel), 32'h4);
        check("fair.ac0", 32'(requireAC), 32'b0001);
        tick();
        check("fair.lbl0", 32'(BClabel), 32'h1);
        check("fair.ac1", 32'(requireAC), 32'b0010);
        tick();
        check("fair.lbl1", 32'(BClabel), 32'h2);
        require = '0;
        tick();

        // Label 0 from mem (pointer at 2): accepted, dropped, sticky error.
        set_src(3, 4'h0, 32'hdead);
        require = 4'b1000;
        #1;
        check("lbl0.ac", 32'(requireAC), 32'b1000);
        tick();
        require = '0;
        check_bus("lbl0.bus", 1'b0, 4'h0, 32'h0);
        check("lbl0.err", 32'(proto_err), 32'h1);
        tick();
        tick();
        check("lbl0.sticky", 32'(proto_err), 32'h1);
        set_src(3, 4'h4, 32'h40);

        // Reset during broadcast: label 7 is lost and never appears.
        set_src(0, 4'h7, 32'h77);
        require = 4'b0001;
        #1;
        check("rstbc.ac", 32'(requireAC), 32'b0001);
        tick();
        require = '0;
        check_bus("rstbc.pre", 1'b1, 4'h7, 32'h77);
        #2;
        nRST = 1'b0;
        #1;
        check_bus("rstbc.drop", 1'b0, 4'h0, 32'h0);
        check("rstbc.err", 32'(proto_err), 32'h0);
        #1;
        nRST = 1'b1;
        tick();
        check_bus("rstbc.after", 1'b0, 4'h0, 32'h0);
        require = 4'b1111;
        #1;
        check("rstbc.ptr0", 32'(requireAC), 32'b0001);
        require = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
